// File: rtl/sdr_host_seq.sv
// sdr_host_seq: host-side request sequencer for the SDR/DDR controller.
// Splits one transfer command into burst requests that never cross a row.
// Optional macro SDR_HOST_TMO_EN adds a req_ack watchdog (xfer_err).
`ifndef U_ADDR_MSB
`define U_ADDR_MSB 22
`endif

module sdr_host_seq #(
  parameter int LEN_W   = 16,
  parameter int GAP_CYC = 2,
  parameter int ACK_TMO = 1023
) (
  input  logic                 clk,
  input  logic                 reset1,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr_n,
  input  logic [`U_ADDR_MSB:0] cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 sdc_sel,
  input  logic [8:0]           bl,
  input  logic                 req_ack,
  output logic [`U_ADDR_MSB:0] u_addr,
  output logic                 sdr_req,
  output logic                 sdr_req_wr_n,
  output logic [9:0]           burst_len,
  output logic                 busy,
  output logic                 xfer_done,
  output logic                 xfer_err
);

  localparam int AW = `U_ADDR_MSB + 1;
  localparam int CW = (LEN_W > 10) ? LEN_W : 10;
  // The CALC cycle is the last idle cycle before a request, so GAP itself
  // lasts GAP_CYC-1 cycles and the total low time between bursts is GAP_CYC.
  localparam logic [7:0] GAP_LAST = 8'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);

  typedef enum logic [2:0] {IDLE, CALC, REQ, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       bank_q, bank_d;
  logic [11:0]      row_q, row_d;
  logic [8:0]       col_q, col_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             sdc_q, sdc_d;
  logic [8:0]       bl_q, bl_d;
  logic [AW-1:0]    u_addr_q, u_addr_d;
  logic [9:0]       burst_len_q, burst_len_d;
  logic             sdr_req_q, sdr_req_d;
  logic             sdr_req_wr_n_q, sdr_req_wr_n_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;

  // Burst sizing and address-advance helpers
  logic [9:0]       cols, room, blv, step, burst, col_sum;
  logic [CW-1:0]    step_w, rem_w;
  logic [LEN_W-1:0] rem_after;

`ifdef SDR_HOST_TMO_EN
  localparam int TMO_W = ($clog2(ACK_TMO + 1) > 10) ? $clog2(ACK_TMO + 1) : 10;
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(ACK_TMO);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Burst length = min(programmed or page, remaining words, room left in row)
  always_comb begin
    cols      = sdc_q ? 10'd512 : 10'd256;
    room      = cols - {1'b0, col_q};
    blv       = (bl_q == 9'd0) ? room : {1'b0, bl_q};
    step      = (blv < room) ? blv : room;
    step_w    = CW'(step);
    rem_w     = CW'(rem_q);
    burst     = (rem_w < step_w) ? rem_w[9:0] : step;
    col_sum   = {1'b0, col_q} + burst_len_q;
    rem_after = rem_q - LEN_W'(burst_len_q);
  end

  // Next-state and output logic for the burst sequencer
  always_comb begin
    state_d        = state_q;
    bank_d         = bank_q;
    row_d          = row_q;
    col_d          = col_q;
    rem_d          = rem_q;
    sdc_d          = sdc_q;
    bl_d           = bl_q;
    u_addr_d       = u_addr_q;
    burst_len_d    = burst_len_q;
    sdr_req_d      = sdr_req_q;
    sdr_req_wr_n_d = sdr_req_wr_n_q;
    gap_cnt_d      = gap_cnt_q;
    xfer_done      = 1'b0;
    xfer_err       = 1'b0;
`ifdef SDR_HOST_TMO_EN
    tmo_cnt_d      = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          bank_d         = cmd_addr[22:21];
          row_d          = cmd_addr[20:9];
          // DDR pages are 256 columns; col[8] is forced low
          col_d          = {sdc_sel & cmd_addr[8], cmd_addr[7:0]};
          rem_d          = cmd_len;
          sdc_d          = sdc_sel;
          bl_d           = bl;
          sdr_req_wr_n_d = cmd_wr_n;
          state_d        = (cmd_len == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        u_addr_d    = AW'({bank_q, row_q, col_q});
        burst_len_d = burst;
        sdr_req_d   = 1'b1;
        state_d     = REQ;
`ifdef SDR_HOST_TMO_EN
        tmo_cnt_d   = '0;
`endif
      end
      REQ: begin
        if (req_ack) begin
          sdr_req_d = 1'b0;
          rem_d     = rem_after;
          gap_cnt_d = 8'd0;
          if (col_sum == cols) begin
            col_d = 9'd0;
            row_d = row_q + 12'd1;
            if (row_q == 12'hFFF) bank_d = bank_q + 2'd1;
          end else begin
            col_d = col_sum[8:0];
          end
          if (GAP_CYC > 1)           state_d = GAP;
          else if (rem_after != '0)  state_d = CALC;
          else                       state_d = DONE;
        end
`ifdef SDR_HOST_TMO_EN
        else if (tmo_cnt_q == TMO_LIM) begin
          xfer_err  = 1'b1;
          sdr_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = (rem_q != '0) ? CALC : DONE;
        else                       gap_cnt_d = gap_cnt_q + 8'd1;
      end
      DONE: begin
        xfer_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset1) begin
      state_q        <= IDLE;
      bank_q         <= '0;
      row_q          <= '0;
      col_q          <= '0;
      rem_q          <= '0;
      sdc_q          <= 1'b0;
      bl_q           <= '0;
      u_addr_q       <= '0;
      burst_len_q    <= '0;
      sdr_req_q      <= 1'b0;
      sdr_req_wr_n_q <= 1'b1;
      gap_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      bank_q         <= bank_d;
      row_q          <= row_d;
      col_q          <= col_d;
      rem_q          <= rem_d;
      sdc_q          <= sdc_d;
      bl_q           <= bl_d;
      u_addr_q       <= u_addr_d;
      burst_len_q    <= burst_len_d;
      sdr_req_q      <= sdr_req_d;
      sdr_req_wr_n_q <= sdr_req_wr_n_d;
      gap_cnt_q      <= gap_cnt_d;
    end
  end

`ifdef SDR_HOST_TMO_EN
  // Watchdog counter for the outstanding request
  always_ff @(posedge clk) begin
    if (reset1) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign u_addr       = u_addr_q;
  assign sdr_req      = sdr_req_q;
  assign sdr_req_wr_n = sdr_req_wr_n_q;
  assign burst_len    = burst_len_q;

endmodule

// File: tb/tb_sdr_host_seq.sv
// Directed bench for sdr_host_seq with a hand-driven controller ack.
module tb_sdr_host_seq;

  logic        clk = 1'b0;
  logic        reset1;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr_n;
  logic [22:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        sdc_sel;
  logic [8:0]  bl;
  logic        req_ack;
  logic [22:0] u_addr;
  logic        sdr_req;
  logic        sdr_req_wr_n;
  logic [9:0]  burst_len;
  logic        busy;
  logic        xfer_done;
  logic        xfer_err;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int rise_cnt = 0;
  logic req_prev = 1'b0;

  sdr_host_seq #(.LEN_W(16), .GAP_CYC(2), .ACK_TMO(20)) dut (
    .clk(clk), .reset1(reset1), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr_n(cmd_wr_n), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .sdc_sel(sdc_sel), .bl(bl), .req_ack(req_ack), .u_addr(u_addr),
    .sdr_req(sdr_req), .sdr_req_wr_n(sdr_req_wr_n), .burst_len(burst_len),
    .busy(busy), .xfer_done(xfer_done), .xfer_err(xfer_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    req_prev <= sdr_req;
    if (xfer_done === 1'b1) done_cnt <= done_cnt + 1;
    if (sdr_req === 1'b1 && req_prev !== 1'b1) rise_cnt <= rise_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [22:0] a, input logic [15:0] l, input logic wn,
                       input logic s, input logic [8:0] b);
    @(posedge clk); #1;
    cmd_addr = a; cmd_len = l; cmd_wr_n = wn; sdc_sel = s; bl = b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Wait for a request, check it, hold it, ack it, then count low cycles.
  task automatic burst(input string tag, input logic [22:0] ea, input logic [9:0] el,
                       input logic ew, input int ack_cyc, output int gap);
    int n;
    n = 0;
    while (sdr_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_req"}, sdr_req, 1);
    chk({tag, "_addr"}, u_addr, ea);
    chk({tag, "_len"}, burst_len, el);
    chk({tag, "_wrn"}, sdr_req_wr_n, ew);
    repeat (2) @(negedge clk);
    chk({tag, "_hold"}, {sdr_req, u_addr, burst_len}, {1'b1, ea, el});
    @(posedge clk); #1 req_ack = 1'b1;
    @(posedge clk); #1 req_ack = (ack_cyc > 1);
    gap = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sdr_req === 1'b1) break;
      gap++;
      @(posedge clk); #1 req_ack = 1'b0;
    end
    req_ack = 1'b0;
  endtask

  initial begin
    int g;
    int d0;
    int r0;
    reset1 = 1'b1; cmd_valid = 1'b0; cmd_wr_n = 1'b1; cmd_addr = '0;
    cmd_len = '0; sdc_sel = 1'b1; bl = 9'd4; req_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {cmd_ready, sdr_req, sdr_req_wr_n, busy, xfer_done, xfer_err},
        {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("rst_addr", {u_addr, burst_len}, 33'd0);
    @(posedge clk); #1 reset1 = 1'b0;

    // 1: SDR bl=4 write, col 0x10, 10 words -> 4/4/2
    d0 = done_cnt;
    issue(23'h000010, 16'd10, 1'b0, 1'b1, 9'd4);
    sdc_sel = 1'b0; bl = 9'd1;   // ignored mid-transfer
    @(negedge clk);
    chk("t1_calc", {sdr_req, busy, cmd_ready}, {1'b0, 1'b1, 1'b0});
    @(negedge clk);
    chk("t1_lat", sdr_req, 1);
    burst("t1_b0", 23'h000010, 10'd4, 1'b0, 1, g);
    chk("t1_gap0", g, 2);
    burst("t1_b1", 23'h000014, 10'd4, 1'b0, 1, g);
    chk("t1_gap1", g, 2);
    burst("t1_b2", 23'h000018, 10'd2, 1'b0, 1, g);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_idle", {cmd_ready, busy}, 2'b10);

    // 2: SDR bl=8 read crossing row 5 -> 6
    issue(23'h000BFC, 16'd8, 1'b1, 1'b1, 9'd8);
    burst("t2_b0", 23'h000BFC, 10'd4, 1'b1, 1, g);
    burst("t2_b1", 23'h000C00, 10'd4, 1'b1, 1, g);
    chk("t2_done", done_cnt - d0, 2);

    // 3: DDR page mode, bank1 row FFF col F0 (col[8] set, must be dropped)
    issue(23'h3FFFF0, 16'd32, 1'b0, 1'b0, 9'd0);
    burst("t3_b0", 23'h3FFEF0, 10'd16, 1'b0, 1, g);
    burst("t3_b1", 23'h400000, 10'd16, 1'b0, 1, g);
    chk("t3_done", done_cnt - d0, 3);

    // 4: zero-length transfer
    r0 = rise_cnt;
    issue(23'h000100, 16'd0, 1'b0, 1'b1, 9'd4);
    @(negedge clk);
    chk("t4_pulse", {xfer_done, sdr_req, busy}, 3'b101);
    @(negedge clk);
    chk("t4_end", {xfer_done, cmd_ready}, 2'b01);
    chk("t4_noreq", rise_cnt - r0, 0);
    chk("t4_done", done_cnt - d0, 4);

    // 5: ack in IDLE and in GAP ignored; reset mid-burst
    @(posedge clk); #1 req_ack = 1'b1;
    @(posedge clk); #1 req_ack = 1'b0;
    @(negedge clk);
    chk("t5_idle_ack", {cmd_ready, busy, sdr_req, xfer_done}, 4'b1000);
    issue(23'h000000, 16'd8, 1'b0, 1'b1, 9'd4);
    burst("t5_b0", 23'h000000, 10'd4, 1'b0, 2, g);
    chk("t5_gap", g, 2);
    burst("t5_b1", 23'h000004, 10'd4, 1'b0, 1, g);
    chk("t5_done", done_cnt - d0, 5);
    issue(23'h000020, 16'd4, 1'b0, 1'b1, 9'd4);
    @(negedge clk); @(negedge clk);
    chk("t5_inreq", {sdr_req, u_addr}, {1'b1, 23'h000020});
    @(posedge clk); #1 reset1 = 1'b1;
    @(posedge clk); #1 reset1 = 1'b0;
    @(negedge clk);
    chk("t5_rst", {cmd_ready, sdr_req, sdr_req_wr_n, busy, xfer_done, xfer_err, u_addr, burst_len},
        {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'd0, 10'd0});
    repeat (4) @(negedge clk);
    chk("t5_rst_quiet", {sdr_req, done_cnt - d0}, {1'b0, 32'd5});

`ifdef SDR_HOST_TMO_EN
    // 6: watchdog with ACK_TMO=20
    issue(23'h000040, 16'd4, 1'b1, 1'b1, 9'd4);
    @(negedge clk);
    @(negedge clk);
    chk("t6_req", sdr_req, 1);
    repeat (19) @(negedge clk);
    chk("t6_pre", {xfer_err, sdr_req}, 2'b01);
    @(negedge clk);
    chk("t6_err", {xfer_err, sdr_req}, 2'b11);
    @(negedge clk);
    chk("t6_after", {xfer_err, sdr_req, cmd_ready}, 3'b001);
    chk("t6_nodone", done_cnt - d0, 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
